// File: rtl/rv32_pkg.sv
// RV32 register-file constants and ABI register names shared by the writeback path and decode.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef enum logic [AW-1:0] {
        ZERO, RA, SP, GP, TP, T0, T1, T2,
        S0, S1, A0, A1, A2, A3, A4, A5,
        A6, A7, S2, S3, S4, S5, S6, S7,
        S8, S9, S10, S11, T3, T4, T5, T6
    } reg_idx_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching upward from the pointer.
// Zero latency; on advance the pointer moves one past the winner, requesters hold until granted.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW  = (N > 1) ? $clog2(N) : 1;
    localparam int PW1 = PW + 1;

    logic [PW-1:0] ptr_q, ptr_d, win;
    logic [PW:0]   sum;
    logic          found;

    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + PW1'(k);
            if (sum >= PW1'(N)) begin
                sum = sum - PW1'(N);
            end
            if (!found && req[sum[PW-1:0]]) begin
                found               = 1'b1;
                win                 = sum[PW-1:0];
                gnt[sum[PW-1:0]]    = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback units and tracks per-register busy bits.
// Write latency 1 (grant -> registered RegWrite/WR/WD); losers and WAW reservations are held off via ready=0.
module regfile_wb_arbiter #(
    parameter int NREQ = 2,
    parameter int XLEN = rv32_pkg::XLEN,
    parameter int NREG = rv32_pkg::NREG,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_rd,
    output logic                 rsv_ready,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_wr,
    input  logic [NREQ*XLEN-1:0] req_wd,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_regwrite,
    output logic [AW-1:0]        rf_wr,
    output logic [XLEN-1:0]      rf_wd,
    input  logic [AW-1:0]        qry_r1,
    input  logic [AW-1:0]        qry_r2,
    output logic                 qry_busy1,
    output logic                 qry_busy2,
    output logic                 err_unreserved
);

    localparam logic [AW-1:0] X0 = AW'(rv32_pkg::ZERO);

    logic [NREG-1:0] busy_q, busy_d;
    logic            rf_regwrite_q;
    logic [AW-1:0]   rf_wr_q;
    logic [XLEN-1:0] rf_wd_q;
    logic            err_q;

    logic [NREQ-1:0] gnt;
    logic            any_gnt;
    logic [AW-1:0]   g_wr;
    logic [XLEN-1:0] g_wd;
    logic            rsv_fire;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (|req_valid),
        .gnt     (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    always_comb begin
        g_wr = '0;
        g_wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g_wr = req_wr[i*AW +: AW];
                g_wd = req_wd[i*XLEN +: XLEN];
            end
        end
    end

    // x0 never becomes busy, so its reservation is always accepted.
    assign rsv_ready = rsv_valid && ((rsv_rd == X0) || !busy_q[rsv_rd]);
    assign rsv_fire  = rsv_ready && (rsv_rd != X0);

    always_comb begin
        busy_d = busy_q;
        if (rf_regwrite_q) begin
            busy_d[rf_wr_q] = 1'b0;
        end
        if (rsv_fire) begin
            busy_d[rsv_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q        <= '0;
            rf_regwrite_q <= 1'b0;
            rf_wr_q       <= '0;
            rf_wd_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            rf_regwrite_q <= any_gnt && (g_wr != X0);
            if (any_gnt) begin
                rf_wr_q <= g_wr;
                rf_wd_q <= g_wd;
            end
            if (rf_regwrite_q && !busy_q[rf_wr_q]) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rf_regwrite    = rf_regwrite_q;
    assign rf_wr          = rf_wr_q;
    assign rf_wd          = rf_wd_q;
    assign qry_busy1      = busy_q[qry_r1];
    assign qry_busy2      = busy_q[qry_r2];
    assign err_unreserved = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized bench for regfile_wb_arbiter against a behavioural scoreboard model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 2;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rsv_valid = 1'b0;
    logic [AW-1:0]        rsv_rd = '0;
    logic                 rsv_ready;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*AW-1:0]   req_wr = '0;
    logic [NREQ*XLEN-1:0] req_wd = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_regwrite;
    logic [AW-1:0]        rf_wr;
    logic [XLEN-1:0]      rf_wd;
    logic [AW-1:0]        qry_r1 = '0;
    logic [AW-1:0]        qry_r2 = '0;
    logic                 qry_busy1, qry_busy2;
    logic                 err_unreserved;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .NREG(NREG)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rsv_valid      (rsv_valid),
        .rsv_rd         (rsv_rd),
        .rsv_ready      (rsv_ready),
        .req_valid      (req_valid),
        .req_wr         (req_wr),
        .req_wd         (req_wd),
        .req_ready      (req_ready),
        .rf_regwrite    (rf_regwrite),
        .rf_wr          (rf_wr),
        .rf_wd          (rf_wd),
        .qry_r1         (qry_r1),
        .qry_r2         (qry_r2),
        .qry_busy1      (qry_busy1),
        .qry_busy2      (qry_busy2),
        .err_unreserved (err_unreserved)
    );

    always #5 clk = ~clk;

    // Reference model: which registers are reserved, whose turn it is, what the RF sees next.
    bit          m_busy [NREG];
    int          m_rr;
    bit          m_we;
    int          m_wr;
    logic [31:0] m_wd;
    bit          m_err;
    int          last_g;
    bit          rnd;
    int          pool[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit exp_rsv_ready();
        return rsv_valid && (rsv_rd == 0 || !m_busy[rsv_rd]);
    endfunction

    task automatic settle_check();
        int g;
        logic [NREQ-1:0] e;
        #1;
        g = exp_grant();
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        check("rsv_ready", rsv_ready, exp_rsv_ready());
        check("req_ready", req_ready, e);
        check("rf_regwrite", rf_regwrite, m_we);
        check("rf_wr", rf_wr, m_wr);
        check("rf_wd", rf_wd, m_wd);
        check("qry_busy1", qry_busy1, qry_r1 != 0 && m_busy[qry_r1]);
        check("qry_busy2", qry_busy2, qry_r2 != 0 && m_busy[qry_r2]);
        check("err_unreserved", err_unreserved, m_err);
    endtask

    task automatic tick();
        int g;
        bit acc;
        g   = exp_grant();
        acc = exp_rsv_ready();
        @(posedge clk);
        if (m_we && !m_busy[m_wr]) m_err = 1'b1;
        if (m_we) m_busy[m_wr] = 1'b0;
        if (acc && rsv_rd != 0) begin
            m_busy[rsv_rd] = 1'b1;
            if (rnd) pool.push_back(int'(rsv_rd));
        end
        if (g >= 0) begin
            m_wr = int'(req_wr[g*AW +: AW]);
            m_wd = req_wd[g*XLEN +: XLEN];
            m_we = (m_wr != 0);
            m_rr = (g + 1) % NREQ;
        end else begin
            m_we = 1'b0;
        end
        last_g = g;
        @(negedge clk);
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    task automatic do_reset();
        rsv_valid = 1'b0;
        req_valid = '0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rsv_ready", rsv_ready, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_regwrite", rf_regwrite, 0);
        check("rst_wr", rf_wr, 0);
        check("rst_wd", rf_wd, 0);
        check("rst_err", err_unreserved, 0);
        for (int r = 0; r < NREG; r++) begin
            qry_r1 = AW'(r);
            qry_r2 = AW'(NREG - 1 - r);
            #1;
            check("rst_busy1", qry_busy1, 0);
            check("rst_busy2", qry_busy2, 0);
        end
        for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        m_rr = 0; m_we = 1'b0; m_wr = 0; m_wd = '0; m_err = 1'b0; last_g = -1;
        pool.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int r0[3];
        int r1[3];
        int n0, n1;
        bit [NREQ-1:0] vld;

        rnd = 1'b0;
        do_reset();

        // Reserve x5, requester 1 writes it.
        qry_r1 = 5; qry_r2 = 0;
        rsv_valid = 1'b1; rsv_rd = 5;
        settle_check();
        check("x5_rsv_ready", rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
        req_valid = 2'b10; req_wr[AW +: AW] = 5; req_wd[XLEN +: XLEN] = 32'hDEADBEEF;
        settle_check();
        check("x5_grant", req_ready, 2'b10);
        check("x5_busy_held", qry_busy1, 1);
        tick();
        req_valid = '0;
        settle_check();
        check("x5_regwrite", rf_regwrite, 1);
        check("x5_wr", rf_wr, 5);
        check("x5_wd", rf_wd, 32'hDEADBEEF);
        check("x5_busy_commit_cycle", qry_busy1, 1);
        tick();
        settle_check();
        check("x5_busy_clear", qry_busy1, 0);
        check("x5_idle_regwrite", rf_regwrite, 0);
        tick();

        // Fairness: both requesters stream writes to pre-reserved registers.
        r0 = '{6, 10, 12};
        r1 = '{7, 11, 13};
        for (int i = 0; i < 3; i++) begin
            rsv_valid = 1'b1; rsv_rd = AW'(r0[i]); step();
            rsv_rd = AW'(r1[i]); step();
        end
        rsv_valid = 1'b0;
        n0 = 0; n1 = 0;
        req_valid = 2'b11;
        req_wr[0 +: AW] = AW'(r0[0]); req_wd[0 +: XLEN] = $urandom;
        req_wr[AW +: AW] = AW'(r1[0]); req_wd[XLEN +: XLEN] = $urandom;
        for (int k = 0; k < 6; k++) begin
            settle_check();
            check("fair_grant", req_ready, (k % 2) ? 2'b10 : 2'b01);
            check("fair_onehot", $countones(req_ready), 1);
            tick();
            if (last_g == 0) begin
                n0++;
                if (n0 < 3) begin req_wr[0 +: AW] = AW'(r0[n0]); req_wd[0 +: XLEN] = $urandom; end
                else req_valid[0] = 1'b0;
            end else if (last_g == 1) begin
                n1++;
                if (n1 < 3) begin req_wr[AW +: AW] = AW'(r1[n1]); req_wd[XLEN +: XLEN] = $urandom; end
                else req_valid[1] = 1'b0;
            end
        end
        req_valid = '0;
        step(); step();

        // WAW: x8 busy, re-reservation held until the cycle after its commit.
        rsv_valid = 1'b1; rsv_rd = 8; step();
        req_valid = 2'b01; req_wr[0 +: AW] = 8; req_wd[0 +: XLEN] = 32'h0BAD_F00D;
        settle_check();
        check("waw_grant_cycle", rsv_ready, 0);
        tick();
        req_valid = '0;
        settle_check();
        check("waw_commit_cycle", rsv_ready, 0);
        tick();
        settle_check();
        check("waw_released", rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
        req_valid = 2'b01; step();
        req_valid = '0; step(); step();

        // x0: reservation accepted, write granted but dropped.
        qry_r1 = 0;
        rsv_valid = 1'b1; rsv_rd = 0;
        settle_check();
        check("x0_rsv_ready", rsv_ready, 1);
        tick();
        rsv_valid = 1'b0;
        req_valid = 2'b01; req_wr[0 +: AW] = 0; req_wd[0 +: XLEN] = 32'h1234;
        settle_check();
        check("x0_grant", req_ready, 2'b01);
        tick();
        req_valid = '0;
        settle_check();
        check("x0_regwrite", rf_regwrite, 0);
        check("x0_busy", qry_busy1, 0);
        check("x0_err", err_unreserved, 0);
        tick();

        // Random traffic: decode reserves, requesters write back what was reserved.
        rnd = 1'b1;
        pool.delete();
        last_g = -1;
        vld = '0;
        for (int c = 0; c < 600; c++) begin
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_rd    = AW'($urandom_range(0, 15));
            qry_r1    = AW'($urandom_range(0, 15));
            qry_r2    = AW'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                if (vld[i] && last_g == i) begin
                    vld[i] = 1'b0;
                end else if (vld[i] && $urandom_range(0, 15) == 0) begin
                    vld[i] = 1'b0;
                    if (req_wr[i*AW +: AW] != 0) pool.push_back(int'(req_wr[i*AW +: AW]));
                end
                if (!vld[i] && $urandom_range(0, 2) != 0) begin
                    if (pool.size() > 0) begin
                        req_wr[i*AW +: AW]     = AW'(pool.pop_front());
                        req_wd[i*XLEN +: XLEN] = $urandom;
                        vld[i] = 1'b1;
                    end else if ($urandom_range(0, 7) == 0) begin
                        req_wr[i*AW +: AW]     = '0;
                        req_wd[i*XLEN +: XLEN] = $urandom;
                        vld[i] = 1'b1;
                    end
                end
            end
            req_valid = vld;
            step();
        end

        // Reset in the middle of traffic.
        rnd = 1'b0;
        do_reset();

        // Unreserved write raises the sticky error but still commits.
        req_valid = 2'b10; req_wr[AW +: AW] = 9; req_wd[XLEN +: XLEN] = 32'h55;
        settle_check();
        check("unrsv_grant", req_ready, 2'b10);
        tick();
        req_valid = '0;
        settle_check();
        check("unrsv_regwrite", rf_regwrite, 1);
        check("unrsv_wr", rf_wr, 9);
        check("unrsv_wd", rf_wd, 32'h55);
        check("unrsv_err_pre", err_unreserved, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            settle_check();
            check("unrsv_err_sticky", err_unreserved, 1);
            tick();
        end
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file and shares it among NREQ writeback requesters (in-order pipeline WB, multi-cycle load/mul units).
- Keeps a per-register busy scoreboard so that the decode/hazard logic can stall on RAW and WAW.
- Sits between the WB/multi-cycle units and the register file write inputs (RegWrite, WR, WD).

Parameters:
NREQ, 2, number of writeback requesters (2..4); index 0 is the in-order pipeline WB.
XLEN, 32, data width.
NREG, 32, architectural register count; index width AW = log2(NREG) = 5.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rsv_valid  in  1  decode reserves destination rsv_rd at issue
rsv_rd  in  AW  destination register to reserve
rsv_ready  out  1  reservation accepted this cycle (combinational)
req_valid  in  NREQ  writeback request per requester
req_wr  in  NREQ*AW  destination register per requester, packed, requester i at [i*AW +: AW]
req_wd  in  NREQ*XLEN  write data per requester, packed
req_ready  out  NREQ  grant, one-hot or zero (combinational)
rf_regwrite  out  1  to register file RegWrite (registered)
rf_wr  out  AW  to register file WR (registered)
rf_wd  out  XLEN  to register file WD (registered)
qry_r1, qry_r2  in  AW  source registers queried by hazard logic
qry_busy1, qry_busy2  out  1  busy[qry_rX] (combinational); always 0 for x0
err_unreserved  out  1  sticky flag: write committed to a non-busy, nonzero register

Behaviour:
- Reset, async on rst_n low:
  - busy[NREG-1:0] = 0
  - round-robin pointer rr = 0
  - rf_regwrite = 0, rf_wr = 0, rf_wd = 0
  - err_unreserved = 0
  - A registered write pending at reset assertion is discarded and its busy bit is lost.
- Reservation:
  - rsv_ready = rsv_valid & (rsv_rd == 0 | ~busy[rsv_rd]).
  - On rsv_valid & rsv_ready with rsv_rd != 0, set busy[rsv_rd] at the next edge.
  - A reservation of a busy register (WAW) is held off until that register clears.
- Arbitration:
  - Round-robin among asserted req_valid, starting the search at index rr.
  - Exactly one req_ready is asserted when any req_valid is high; otherwise all are 0.
  - On a grant to index g, rr <= (g+1) mod NREQ at the next edge; rr is unchanged when there is no grant.
  - Requesters hold req_valid, req_wr and req_wd stable until they see req_ready. Dropping req_valid before a grant is legal.
- Write path, latency 1:
  - A grant in cycle t registers rf_regwrite = (req_wr != 0), rf_wr = req_wr, rf_wd = req_wd; these are visible during cycle t+1.
  - The register file commits at the end of t+1.
  - Without a grant, rf_regwrite = 0 and rf_wr/rf_wd hold their previous values.
  - Throughput is one write per cycle.
- Busy clear:
  - At the end of cycle t+1, the same edge as the register file commit, clear busy[rf_wr] when rf_regwrite = 1.
  - A query in t+2 therefore reads busy = 0 and the register file holds the new data. There is no bypass in this block.
- Simultaneous events:
  - Set and clear of the same register on one edge cannot occur, because rsv_ready = 0 while busy.
  - Set and clear of different registers both take effect.
- x0:
  - Writes to x0 are granted but dropped (rf_regwrite = 0).
  - Reservations of x0 are accepted and have no effect.
  - busy[0] is always 0.
- Error: if rf_regwrite = 1 and busy[rf_wr] = 0, set err_unreserved; it is cleared only by reset. The write still commits.

Decomposition:
- Shared package (rv32_pkg):
  - XLEN, NREG, AW constants
  - register index enum names (ZERO, RA, SP, ...)
- Sub-module rr_arbiter:
  - parameter N
  - inputs req[N], advance; output gnt[N] one-hot
  - internal pointer with async active-low reset
  - reusable elsewhere, for example in the memory port arbiter.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles mid-traffic -> all outputs 0, qry_busy1/2 = 0 for every register, err_unreserved = 0.
- Reserve x5, then requester 1 writes x5 = 0xDEADBEEF -> qry_busy1 (qry_r1 = 5) is 1 from the reservation edge until the rf commit edge; rf_regwrite = 1, rf_wr = 5, rf_wd = 0xDEADBEEF one cycle after the grant; busy = 0 the cycle after that.
- Fairness: both requesters valid continuously for 6 cycles to x6/x7 (reserved) -> grants alternate 0,1,0,1,0,1; exactly one req_ready per cycle.
- WAW stall: x8 busy, rsv_valid with rsv_rd = 8 -> rsv_ready = 0 until the cycle after the x8 write commits, then 1.
- x0: reserve x0 and write x0 = 0x1234 -> req_ready = 1, rf_regwrite = 0, qry_busy = 0, err_unreserved stays 0.
- Unreserved write to x9 = 0x55 -> commits (rf_wr = 9, rf_wd = 0x55); err_unreserved rises and stays 1 until rst_n low.
